// File: rtl/sys_run_ctrl.sv
// CPU run/pause/single-step controller: issues one-cycle clock-enable pulses to a
// CPU in free-run (every DIVISOR cycles) or single-step mode, and stops for good on halt.
module sys_run_ctrl #(
  parameter int DIVISOR = 1
) (
  input  logic        clk,
  input  logic        SYS_reset,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        halt_req,
  output logic        cpu_en,
  output logic        CLK_led,
  output logic [31:0] cycle_cnt,
  output logic [1:0]  run_state
);

  typedef enum logic [1:0] {
    ST_PAUSE = 2'b00,
    ST_RUN   = 2'b01,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [23:0] DIV_LAST = 24'(DIVISOR - 1);

  state_e      state_r;
  logic [23:0] div_cnt_r;
  logic        run_meta_r;
  logic        run_sync_r;
  logic        step_meta_r;
  logic        step_sync_r;
  logic        step_prev_r;
  logic        step_evt_s;

  // A step is a rising edge of the synchronized button.
  assign step_evt_s = step_sync_r & ~step_prev_r;
  assign run_state  = state_r;

  // Two-flop synchronizers for the asynchronous switch and button, plus step edge history.
  always_ff @(posedge clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      run_meta_r  <= 1'b0;
      run_sync_r  <= 1'b0;
      step_meta_r <= 1'b0;
      step_sync_r <= 1'b0;
      step_prev_r <= 1'b0;
    end else begin
      run_meta_r  <= run_sw;
      run_sync_r  <= run_meta_r;
      step_meta_r <= step_btn;
      step_sync_r <= step_meta_r;
      step_prev_r <= step_sync_r;
    end
  end

  // Run-control state machine with registered enable, LED and pulse counter.
  always_ff @(posedge clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      state_r   <= ST_PAUSE;
      div_cnt_r <= 24'd0;
      cpu_en    <= 1'b0;
      CLK_led   <= 1'b0;
      cycle_cnt <= 32'd0;
    end else begin
      if (cpu_en) begin
        cycle_cnt <= cycle_cnt + 32'd1;
        CLK_led   <= ~CLK_led;
      end
      cpu_en <= 1'b0;
      // Halt wins over everything else and DONE is only left through reset.
      if (halt_req) begin
        state_r   <= ST_DONE;
        div_cnt_r <= 24'd0;
      end else begin
        case (state_r)
          ST_PAUSE: begin
            if (run_sync_r) begin
              state_r   <= ST_RUN;
              div_cnt_r <= 24'd0;
            end else if (step_evt_s) begin
              cpu_en <= 1'b1;
            end
          end
          ST_RUN: begin
            if (!run_sync_r) begin
              state_r   <= ST_PAUSE;
              div_cnt_r <= 24'd0;
            end else if (div_cnt_r == DIV_LAST) begin
              div_cnt_r <= 24'd0;
              cpu_en    <= 1'b1;
            end else begin
              div_cnt_r <= div_cnt_r + 24'd1;
            end
          end
          ST_DONE: begin
            state_r <= ST_DONE;
          end
          default: begin
            // The unused code stops the CPU rather than letting it run.
            state_r   <= ST_DONE;
            div_cnt_r <= 24'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sys_run_ctrl.sv
// Bench for sys_run_ctrl: three instances (DIVISOR 1, 3, 4) share stimulus and are
// compared every cycle against a timeline-based reference model, plus vector tables.
module tb_sys_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_sw;
  logic        step_btn;
  logic        halt_req;
  logic        en_s  [3];
  logic        led_s [3];
  logic [31:0] cnt_s [3];
  logic [1:0]  st_s  [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sys_run_ctrl #(.DIVISOR(1)) d1 (
    .clk(clk), .SYS_reset(rst_n), .run_sw(run_sw), .step_btn(step_btn), .halt_req(halt_req),
    .cpu_en(en_s[0]), .CLK_led(led_s[0]), .cycle_cnt(cnt_s[0]), .run_state(st_s[0]));
  sys_run_ctrl #(.DIVISOR(3)) d3 (
    .clk(clk), .SYS_reset(rst_n), .run_sw(run_sw), .step_btn(step_btn), .halt_req(halt_req),
    .cpu_en(en_s[1]), .CLK_led(led_s[1]), .cycle_cnt(cnt_s[1]), .run_state(st_s[1]));
  sys_run_ctrl #(.DIVISOR(4)) d4 (
    .clk(clk), .SYS_reset(rst_n), .run_sw(run_sw), .step_btn(step_btn), .halt_req(halt_req),
    .cpu_en(en_s[2]), .CLK_led(led_s[2]), .cycle_cnt(cnt_s[2]), .run_state(st_s[2]));

  // Reference model: mode 0=pause 1=run 3=done; run timing kept as edges since entry.
  int          divs [3] = '{1, 3, 4};
  int          m_mode [3];
  int          m_el [3];
  logic        m_en [3];
  logic        m_led [3];
  logic [31:0] m_cnt [3];
  logic        run_q [$];
  logic        step_q [$];

  typedef struct {
    logic        run;
    logic        step;
    logic        halt;
    logic        en;
    logic [1:0]  st;
    logic [31:0] cnt;
  } vec_t;
  vec_t tab [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    run_q.delete();
    step_q.delete();
    for (int k = 0; k < 3; k++) begin
      m_mode[k] = 0;
      m_el[k]   = 0;
      m_en[k]   = 1'b0;
      m_led[k]  = 1'b0;
      m_cnt[k]  = 32'd0;
    end
  endtask

  // Inputs seen by decisions are those sampled two edges earlier.
  task automatic model_edge();
    logic rs, s2, s3, ev, nxt;
    run_q.push_front(run_sw);
    step_q.push_front(step_btn);
    if (run_q.size() > 4) void'(run_q.pop_back());
    if (step_q.size() > 4) void'(step_q.pop_back());
    rs = (run_q.size() > 2) ? run_q[2] : 1'b0;
    s2 = (step_q.size() > 2) ? step_q[2] : 1'b0;
    s3 = (step_q.size() > 3) ? step_q[3] : 1'b0;
    ev = s2 & ~s3;
    for (int k = 0; k < 3; k++) begin
      nxt = 1'b0;
      if (m_en[k]) begin
        m_cnt[k] = m_cnt[k] + 32'd1;
        m_led[k] = ~m_led[k];
      end
      if (m_mode[k] == 3) begin
        m_mode[k] = 3;
      end else if (halt_req) begin
        m_mode[k] = 3;
      end else if (m_mode[k] == 0) begin
        if (rs) begin
          m_mode[k] = 1;
          m_el[k]   = 0;
        end else if (ev) begin
          nxt = 1'b1;
        end
      end else begin
        if (!rs) begin
          m_mode[k] = 0;
        end else begin
          m_el[k]++;
          nxt = ((m_el[k] % divs[k]) == 0);
        end
      end
      m_en[k] = nxt;
    end
  endtask

  task automatic cmp_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("cpu_en d%0d", divs[k]), 32'(en_s[k]), 32'(m_en[k]));
      chk($sformatf("CLK_led d%0d", divs[k]), 32'(led_s[k]), 32'(m_led[k]));
      chk($sformatf("cycle_cnt d%0d", divs[k]), cnt_s[k], m_cnt[k]);
      chk($sformatf("run_state d%0d", divs[k]), 32'(st_s[k]), 32'(m_mode[k]));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    cmp_all();
  endtask

  // Assert reset between edges, check outputs clear at once, release on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    run_sw   = 1'b0;
    step_btn = 1'b0;
    halt_req = 1'b0;
    rst_n    = 1'b0;

    for (int i = 0; i < 18; i++)
      tab[i] = '{1'b0, ((i % 6) < 2), 1'b0, ((i % 6) == 2), 2'b00, 32'((i + 3) / 6)};
    tab[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 32'd3};
    for (int i = 19; i < 24; i++)
      tab[i] = '{1'b1, ((i % 2) == 1), 1'b0, 1'b0, 2'b11, 32'd3};

    do_reset();

    // Three step presses in PAUSE, then halt together with run and step, then ignored inputs.
    for (int i = 0; i < 24; i++) begin
      run_sw   = tab[i].run;
      step_btn = tab[i].step;
      halt_req = tab[i].halt;
      cyc();
      chk($sformatf("tab%0d cpu_en", i), 32'(en_s[0]), 32'(tab[i].en));
      chk($sformatf("tab%0d run_state", i), 32'(st_s[0]), 32'(tab[i].st));
      chk($sformatf("tab%0d cycle_cnt", i), cnt_s[0], tab[i].cnt);
    end

    // Free run: entry two edges after sampling, DIVISOR=4 pulse spacing, DIVISOR=1 always on.
    run_sw   = 1'b1;
    step_btn = 1'b0;
    do_reset();
    cyc();
    cyc();
    chk("run entry early", 32'(st_s[2]), 32'd0);
    cyc();
    chk("run entry", 32'(st_s[2]), 32'd1);
    for (int k = 1; k <= 23; k++) begin
      cyc();
      chk($sformatf("d4 pulse k%0d", k), 32'(en_s[2]), 32'((k % 4) == 0));
      chk($sformatf("d1 pulse k%0d", k), 32'(en_s[0]), 32'd1);
      if (k == 21) begin
        chk("d4 five pulses cnt", cnt_s[2], 32'd5);
        chk("d4 five pulses led", 32'(led_s[2]), 32'd1);
      end
    end

    // Drop run while the DIVISOR=3 counter is mid-period, then re-enter.
    run_sw = 1'b0;
    for (int k = 24; k <= 26; k++) cyc();
    chk("d3 paused", 32'(st_s[1]), 32'd0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("d3 no pulse paused", 32'(en_s[1]), 32'd0);
    end
    run_sw = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("d3 reenter", 32'(st_s[1]), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk($sformatf("d3 reentry k%0d", k), 32'(en_s[1]), 32'(k == 3));
    end

    // Halt in RUN together with run/step changes; everything afterwards is ignored.
    halt_req = 1'b1;
    run_sw   = 1'b0;
    step_btn = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) chk("halt state", 32'(st_s[k]), 32'd3);
    halt_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      run_sw   = ~run_sw;
      step_btn = ~step_btn;
      cyc();
      chk("done en", 32'(en_s[0]), 32'd0);
      chk("done state", 32'(st_s[0]), 32'd3);
    end

    // A step button already high at release counts as a fresh press.
    run_sw   = 1'b0;
    step_btn = 1'b1;
    do_reset();
    cyc();
    cyc();
    chk("fresh step early", 32'(en_s[0]), 32'd0);
    cyc();
    chk("fresh step pulse", 32'(en_s[0]), 32'd1);
    cyc();
    chk("fresh step single", 32'(en_s[0]), 32'd0);

    // Counter wrap on the DIVISOR=1 instance.
    run_sw   = 1'b1;
    step_btn = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    #3;
    force d1.cycle_cnt = 32'hFFFF_FFFE;
    #1;
    release d1.cycle_cnt;
    m_cnt[0] = 32'hFFFF_FFFE;
    cyc();
    chk("wrap ffffffff", cnt_s[0], 32'hFFFF_FFFF);
    cyc();
    chk("wrap zero", cnt_s[0], 32'd0);

    // Reset between edges in RUN, then run_sw held high restarts from scratch.
    cyc();
    #2;
    do_reset();
    chk("mid reset cnt d4", cnt_s[2], 32'd0);
    cyc();
    cyc();
    cyc();
    chk("run after reset", 32'(st_s[0]), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
      halt_req = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 59) == 0) do_reset();
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
